// File: rtl/aes256_key_expansion_pkg.sv
// Shared AES-256 key-schedule definitions: sizes, Rcon table, FSM encoding
// and the byte/word helpers used by the schedule word generator.
package aes256_key_expansion_pkg;

    localparam int AES256_KEY_WORDS = 60;
    localparam int AES256_ROUNDS    = 14;

    // Index 0 is never used: Rcon[k/8] is only consumed for k = 8..56.
    localparam logic [7:0] RCON [8] = '{8'h00, 8'h01, 8'h02, 8'h04,
                                        8'h08, 8'h10, 8'h20, 8'h40};

    localparam logic [7:0] GF_INV_EXP = 8'hFE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } kx_state_e;

    function automatic logic [7:0] gf_mul_f(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i[2:0]]) acc = acc ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return acc;
    endfunction

    // S-box = affine(x^254) in GF(2^8); x^254 is the inverse, and maps 0 to 0.
    function automatic logic [7:0] s_box_f(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gf_mul_f(inv, inv);
            if (GF_INV_EXP[i[2:0]]) inv = gf_mul_f(inv, x);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word_f(input logic [31:0] w);
        return {s_box_f(w[31:24]), s_box_f(w[23:16]), s_box_f(w[15:8]), s_box_f(w[7:0])};
    endfunction

    // Byte 0 sits in the LSBs, so the FIPS left-rotate is a right-rotate here.
    function automatic logic [31:0] rot_word_f(input logic [31:0] w);
        return {w[7:0], w[31:8]};
    endfunction

endpackage

// File: rtl/aes256_key_word_gen.sv
// Combinational generator for one AES-256 schedule word w[k] from w[k-1],
// w[k-8] and the word index k.
module aes256_key_word_gen
    import aes256_key_expansion_pkg::*;
(
    input  logic [31:0] prev_i,
    input  logic [31:0] back8_i,
    input  logic [5:0]  idx_i,
    output logic [31:0] word_o
);

    logic [31:0] temp_w;

    always_comb begin
        temp_w = prev_i;
        if (idx_i[2:0] == 3'd0) begin
            temp_w = sub_word_f(rot_word_f(prev_i)) ^ {24'h000000, RCON[idx_i[5:3]]};
        end else if (idx_i[2:0] == 3'd4) begin
            temp_w = sub_word_f(prev_i);
        end
        word_o = back8_i ^ temp_w;
    end

endmodule

// File: rtl/aes256_key_expansion.sv
// Iterative AES-256 key schedule: accepts a 256-bit key and expands it into
// 15 round keys held in a flat register bank, WORDS_PER_CYCLE words per clock.
module aes256_key_expansion
    import aes256_key_expansion_pkg::*;
#(
    parameter int WORDS_PER_CYCLE = 1
)
(
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [255:0]                     key_in_tdata,
    input  logic                             key_in_tvalid,
    output logic                             key_in_tready,
    output logic [(AES256_ROUNDS+1)*128-1:0] round_keys,
    output logic                             round_keys_valid,
    output logic                             busy
);

    if (!(WORDS_PER_CYCLE == 1 || WORDS_PER_CYCLE == 2 || WORDS_PER_CYCLE == 4)) begin : g_bad_wpc
        $error("aes256_key_expansion: WORDS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [5:0] STEP  = 6'(WORDS_PER_CYCLE);
    localparam int         SEL_W = (WORDS_PER_CYCLE > 1) ? $clog2(WORDS_PER_CYCLE) : 1;

    kx_state_e                               state_q;
    logic [5:0]                              cnt_q;
    logic                                    ready_q;
    logic                                    valid_q;
    logic                                    busy_q;
    logic [AES256_KEY_WORDS-1:0][31:0]       bank_q;
    logic [AES256_KEY_WORDS-1:0][31:0]       bank_d;
    logic [31:0]                             gen_word [WORDS_PER_CYCLE];
    logic                                    key_hs;
    logic                                    last_group;

    assign key_hs     = key_in_tvalid & ready_q;
    assign last_group = (cnt_q + STEP) == 6'(AES256_KEY_WORDS);

    // Words in one group are chained: word gi uses word gi-1 of the same clock.
    genvar gi;
    generate
        for (gi = 0; gi < WORDS_PER_CYCLE; gi++) begin : g_word
            logic [31:0] prev_w;
            if (gi == 0) begin : g_first
                assign prev_w = bank_q[cnt_q - 6'd1];
            end else begin : g_chain
                assign prev_w = gen_word[gi-1];
            end
            aes256_key_word_gen u_word_gen (
                .prev_i  (prev_w),
                .back8_i (bank_q[cnt_q + 6'(gi) - 6'd8]),
                .idx_i   (cnt_q + 6'(gi)),
                .word_o  (gen_word[gi])
            );
        end
    endgenerate

    always_comb begin
        bank_d = bank_q;
        if (key_hs) begin
            bank_d[7:0] = key_in_tdata;
        end else if (state_q == EXPAND) begin
            for (int i = 0; i < WORDS_PER_CYCLE; i++) begin
                bank_d[cnt_q + 6'(i)] = gen_word[SEL_W'(i)];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 6'd8;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            bank_q  <= '0;
        end else begin
            bank_q <= bank_d;
            case (state_q)
                IDLE, DONE: begin
                    ready_q <= 1'b1;
                    if (key_hs) begin
                        state_q <= EXPAND;
                        cnt_q   <= 6'd8;
                        ready_q <= 1'b0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                EXPAND: begin
                    cnt_q <= cnt_q + STEP;
                    if (last_group) begin
                        state_q <= DONE;
                        ready_q <= 1'b1;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign key_in_tready    = ready_q;
    assign round_keys       = bank_q;
    assign round_keys_valid = valid_q;
    assign busy             = busy_q;

endmodule
